// File: rtl/sw_debounce_pkg.sv
// Shared board constants and types for the switch conditioning stage.
// The default sample period is derived from the board clock and debounce interval.
package sw_debounce_pkg;

  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned SW_WIDTH         = 16;
  localparam int unsigned DEBOUNCE_MS      = 1;
  localparam int unsigned TICK_DIV_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned STABLE_N_DEFAULT = 4;

  // Per-bit verdict taken every cycle from the sample history.
  typedef enum logic [1:0] {
    DecHold,
    DecRise,
    DecFall
  } dec_e;

  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchroniser, tick-sampled history, and
// level/rise/fall decision. chg_next exposes the pending edge so the top can register change_o.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_N = STABLE_N_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic chg_next
);

  logic                sync1_q, sync2_q;
  logic [STABLE_N-1:0] hist_q, hist_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  dec_e                dec;

  always_comb begin
    hist_d = hist_q;
    if (tick) begin
      hist_d = {hist_q[STABLE_N-2:0], sync2_q};
    end
  end

  // A new level is accepted only when every retained sample agrees with it.
  always_comb begin
    dec = DecHold;
    if ((&hist_q) && !level_q) begin
      dec = DecRise;
    end else if (!(|hist_q) && level_q) begin
      dec = DecFall;
    end
  end

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (dec)
      DecRise: begin
        level_d = 1'b1;
        rise_d  = 1'b1;
      end
      DecFall: begin
        level_d = 1'b0;
        fall_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign chg_next = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning top: shared sample-tick prescaler, WIDTH debounce channels,
// and a registered any-bit-changed strobe aligned with sw_o.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH    = SW_WIDTH,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned STABLE_N = STABLE_N_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o,
  output logic             tick_o
);

  localparam int unsigned     CntW   = cnt_width(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             change_q, change_d;
  logic [WIDTH-1:0] chg_next;

  always_comb begin
    tick_d   = (cnt_q == CntMax);
    cnt_d    = tick_d ? '0 : cnt_q + CntW'(1);
    change_d = |chg_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      change_q <= change_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_N(STABLE_N)
    ) u_bit (
      .clk     (clk_i),
      .rst     (rst_i),
      .tick    (tick_q),
      .sw_raw  (sw_i[i]),
      .level   (sw_o[i]),
      .rise    (rise_o[i]),
      .fall    (fall_o[i]),
      .chg_next(chg_next[i])
    );
  end

  assign tick_o   = tick_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: sample-list reference model checked every cycle, plus
// hand-computed checkpoints counted in clock edges since the last reset release.
module tb_sw_debounce;

  localparam int T = 4;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] sw_i;
  logic [15:0] sw_o, rise_o, fall_o;
  logic        change_o, tick_o;

  int n_chk  = 0;
  int n_fail = 0;

  sw_debounce #(
    .WIDTH   (16),
    .TICK_DIV(T),
    .STABLE_N(N)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .sw_i    (sw_i),
    .sw_o    (sw_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .change_o(change_o),
    .tick_o  (tick_o)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs as seen at each rising edge, and edges since reset release.
  logic [15:0] cap_sw;
  logic        cap_rst;
  logic        started = 1'b0;
  int          ecnt = 0;

  always @(posedge clk) begin
    cap_sw  <= sw_i;
    cap_rst <= rst_i;
    started <= 1'b1;
    ecnt    <= rst_i ? 0 : ecnt + 1;
  end

  // Reference model: edge e samples the input seen at edge e-2 whenever e-1 is a
  // positive multiple of T; the level follows the last N samples once they agree.
  int          m_e;
  logic [15:0] m_in[$];
  logic [15:0] m_samp[$];
  logic [15:0] m_lvl, m_rise, m_fall;
  logic        m_tick;

  task automatic model_step(input logic r, input logic [15:0] s);
    logic [15:0] all1, all0;
    if (r) begin
      m_e = 0;
      m_in.delete();
      m_samp.delete();
      m_lvl  = '0;
      m_rise = '0;
      m_fall = '0;
      m_tick = 1'b0;
    end else begin
      m_e++;
      m_in.push_back(s);
      m_rise = '0;
      m_fall = '0;
      if (m_samp.size() >= N) begin
        all1 = '1;
        all0 = '1;
        for (int j = 0; j < N; j++) begin
          all1 &= m_samp[m_samp.size() - 1 - j];
          all0 &= ~m_samp[m_samp.size() - 1 - j];
        end
        m_rise = all1 & ~m_lvl;
        m_fall = all0 & m_lvl;
        m_lvl  = (m_lvl | m_rise) & ~m_fall;
      end
      if (m_e - 1 >= T && (m_e - 1) % T == 0) m_samp.push_back(m_in[m_e - 3]);
      m_tick = (m_e % T == 0);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      model_step(cap_rst, cap_sw);
      chk("model sw_o", 32'(sw_o), 32'(m_lvl));
      chk("model rise_o", 32'(rise_o), 32'(m_rise));
      chk("model fall_o", 32'(fall_o), 32'(m_fall));
      chk("model change_o", 32'(change_o), 32'(|(m_rise | m_fall)));
      chk("model tick_o", 32'(tick_o), 32'(m_tick));
    end
  end

  // Wait for the falling edge following edge k after the last reset release.
  task automatic at_edge(input int k);
    int guard = 0;
    while (ecnt != k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (ecnt != k) begin
      n_chk++;
      n_fail++;
      $display("FAIL at_edge: edge count %0d, required %0d", ecnt, k);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    sw_i  = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset sw_o", 32'(sw_o), 32'h0);
    chk("reset rise_o", 32'(rise_o), 32'h0);
    chk("reset change_o", 32'(change_o), 32'h0);
    chk("reset tick_o", 32'(tick_o), 32'h0);
    rst_i = 1'b0;

    // Tick timebase and power-up acceptance of switches already high.
    at_edge(3);  chk("tick e3", 32'(tick_o), 32'h0);
    at_edge(4);  chk("tick e4", 32'(tick_o), 32'h1);
    at_edge(5);  chk("tick e5", 32'(tick_o), 32'h0);
    at_edge(8);  chk("tick e8", 32'(tick_o), 32'h1);
    at_edge(13); chk("powerup sw_o e13", 32'(sw_o), 32'h0);
    at_edge(14);
    chk("powerup sw_o e14", 32'(sw_o), 32'hFFFF);
    chk("powerup rise_o e14", 32'(rise_o), 32'hFFFF);
    chk("powerup change_o e14", 32'(change_o), 32'h1);
    at_edge(15);
    chk("powerup rise_o e15", 32'(rise_o), 32'h0);
    chk("powerup change_o e15", 32'(change_o), 32'h0);
    sw_i = 16'h0000;
    at_edge(40); chk("all low sw_o", 32'(sw_o), 32'h0);

    // Clean press on bit 0.
    sw_i = 16'h0001;
    at_edge(53); chk("press sw_o e53", 32'(sw_o), 32'h0);
    at_edge(54);
    chk("press sw_o e54", 32'(sw_o), 32'h0001);
    chk("press rise_o e54", 32'(rise_o), 32'h0001);
    chk("press fall_o e54", 32'(fall_o), 32'h0);
    chk("press change_o e54", 32'(change_o), 32'h1);
    at_edge(55);
    chk("press rise_o e55", 32'(rise_o), 32'h0);
    chk("press change_o e55", 32'(change_o), 32'h0);

    // Bounce on bit 3: toggle every 3 cycles, then hold high.
    at_edge(60);
    sw_i = 16'h0009;
    for (int c = 63; c <= 99; c += 3) begin
      at_edge(c);
      sw_i[3] = ~sw_i[3];
    end
    at_edge(100);
    sw_i = 16'h0009;
    at_edge(109); chk("bounce sw_o e109", 32'(sw_o), 32'h0001);
    at_edge(110);
    chk("bounce sw_o e110", 32'(sw_o), 32'h0009);
    chk("bounce rise_o e110", 32'(rise_o), 32'h0008);

    // Simultaneous rise on bit 15 and fall on bit 1.
    at_edge(112);
    sw_i = 16'h0002;
    at_edge(140); chk("simul pre sw_o", 32'(sw_o), 32'h0002);
    sw_i = 16'h8000;
    at_edge(153); chk("simul sw_o e153", 32'(sw_o), 32'h0002);
    at_edge(154);
    chk("simul sw_o e154", 32'(sw_o), 32'h8000);
    chk("simul rise_o e154", 32'(rise_o), 32'h8000);
    chk("simul fall_o e154", 32'(fall_o), 32'h0002);
    chk("simul change_o e154", 32'(change_o), 32'h1);
    at_edge(155);
    chk("simul change_o e155", 32'(change_o), 32'h0);
    chk("simul fall_o e155", 32'(fall_o), 32'h0);

    // Reset after two of three samples of bit 5.
    at_edge(160);
    sw_i = 16'h8020;
    at_edge(170); chk("midwin sw_o e170", 32'(sw_o), 32'h8000);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midwin reset sw_o", 32'(sw_o), 32'h0);
    rst_i = 1'b0;
    at_edge(13); chk("midwin sw_o e13", 32'(sw_o), 32'h0);
    at_edge(14);
    chk("midwin sw_o e14", 32'(sw_o), 32'h8020);
    chk("midwin rise_o e14", 32'(rise_o), 32'h8020);

    // One-cycle glitch on bit 7 that no tick samples.
    at_edge(20);
    sw_i = 16'h80A0;
    at_edge(21);
    sw_i = 16'h8020;
    at_edge(40);
    chk("glitch sw_o", 32'(sw_o), 32'h8020);
    chk("glitch rise_o", 32'(rise_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
